// File: rtl/draw_card.sv
// Card overlay for the VGA chain: ROM addressing, keyed compositing
// and a frame-synchronous left-to-right flip wipe.
module draw_card #(
  parameter int          IMG_W    = 48,
  parameter int          IMG_H    = 64,
  parameter logic [11:0] BACK_RGB = 12'h35A,
  parameter logic [11:0] KEY_RGB  = 12'hF0F,
  parameter int          STEP     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic        reveal,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        busy
);

  localparam logic [1:0] HIDDEN  = 2'd0;
  localparam logic [1:0] OPENING = 2'd1;
  localparam logic [1:0] SHOWN   = 2'd2;
  localparam logic [1:0] CLOSING = 2'd3;

  localparam logic [7:0] WMAX  = 8'(IMG_W);
  localparam logic [7:0] WSTEP = 8'(STEP);

  typedef struct packed {
    logic [10:0] hc;
    logic        hs;
    logic        hb;
    logic [10:0] vc;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
  } tm_t;

  logic        vb_q;
  logic        fs;
  logic [1:0]  st, st_nxt;
  logic [6:0]  w, w_nxt;
  logic [7:0]  w_up;
  logic [10:0] xl, yl;

  assign fs   = vblnk_in & ~vb_q;
  assign w_up = {1'b0, w} + WSTEP;

  always_comb begin
    st_nxt = st;
    w_nxt  = w;
    case (st)
      HIDDEN: begin
        if (reveal) st_nxt = OPENING;
      end
      OPENING: begin
        if (!reveal) begin
          st_nxt = CLOSING;
        end else if (w_up >= WMAX) begin
          w_nxt  = WMAX[6:0];
          st_nxt = SHOWN;
        end else begin
          w_nxt = w_up[6:0];
        end
      end
      SHOWN: begin
        if (!reveal) st_nxt = CLOSING;
      end
      default: begin
        if (reveal) begin
          st_nxt = OPENING;
        end else if ({1'b0, w} <= WSTEP) begin
          w_nxt  = '0;
          st_nxt = HIDDEN;
        end else begin
          w_nxt = w - WSTEP[6:0];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb_q <= 1'b0;
      st   <= HIDDEN;
      w    <= '0;
      xl   <= '0;
      yl   <= '0;
      busy <= 1'b0;
    end else begin
      vb_q <= vblnk_in;
      if (fs) begin
        st   <= st_nxt;
        w    <= w_nxt;
        xl   <= xpos;
        yl   <= ypos;
        busy <= (st_nxt == OPENING) || (st_nxt == CLOSING);
      end
    end
  end

  // 12-bit compares so a card near the right edge never wraps to x=0
  tm_t        t0, t1, t2;
  logic [11:0] hx, vx, x0, y0;
  logic        in_r, in1, in2;
  logic [5:0]  lx, ly, lx1, lx2;
  logic [11:0] pix;

  assign t0 = {hcount_in, hsync_in, hblnk_in,
               vcount_in, vsync_in, vblnk_in, rgb_in};
  assign hx = {1'b0, hcount_in};
  assign vx = {1'b0, vcount_in};
  assign x0 = {1'b0, xl};
  assign y0 = {1'b0, yl};
  assign in_r = (hx >= x0) && (hx < x0 + 12'(IMG_W)) &&
                (vx >= y0) && (vx < y0 + 12'(IMG_H));
  assign lx = hcount_in[5:0] - xl[5:0];
  assign ly = vcount_in[5:0] - yl[5:0];

  always_comb begin
    pix = rom_rgb;
    if (t2.hb || t2.vb)
      pix = 12'h000;
    else if (!in2)
      pix = t2.rgb;
    else if ({1'b0, lx2} >= w)
      pix = BACK_RGB;
    else if (rom_rgb == KEY_RGB)
      pix = t2.rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1         <= '0;
      t2         <= '0;
      in1        <= 1'b0;
      in2        <= 1'b0;
      lx1        <= '0;
      lx2        <= '0;
      rom_addr   <= '0;
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      t1         <= t0;
      in1        <= in_r;
      lx1        <= lx;
      rom_addr   <= in_r ? {ly, lx} : 12'h000;
      t2         <= t1;
      in2        <= in1;
      lx2        <= lx1;
      hcount_out <= t2.hc;
      hsync_out  <= t2.hs;
      hblnk_out  <= t2.hb;
      vcount_out <= t2.vc;
      vsync_out  <= t2.vs;
      vblnk_out  <= t2.vb;
      rgb_out    <= pix;
    end
  end

endmodule
